// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the 16-bit accumulator CPU.
//
// Single-cycle ops (ADD/SUB/AND/OR/NOT/SHL/SHR/PASS) are computed from the
// operands present at the start edge and registered with a one-cycle latency.
// MUL is an unsigned WIDTH-step shift-add multiplier; the 2*WIDTH-bit product
// is split across result (low word) and result_hi (high word).
// Results and flags hold until the next completion.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   launch an operation (sampled only in IDLE)
//   op         in   [3:0] operation code, sampled with start
//   acc_in     in   [WIDTH-1:0] accumulator operand A
//   alu_x      in   [WIDTH-1:0] buffer-register operand X
//   result     out  [WIDTH-1:0] result / low product word
//   result_hi  out  [WIDTH-1:0] high product word, 0 for non-MUL ops
//   flag_z/n/c/v out zero / negative / carry-borrow-shiftout / overflow
//   busy       out  multiply in progress
//   done       out  one-cycle completion pulse
//
// Handshake: start is accepted on a rising edge only while busy=0; each
// accepted start produces exactly one done pulse (next cycle for single-cycle
// ops, 16 cycles later for MUL). start while busy=1 is dropped, not queued.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;
  logic [CW-1:0]    count;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;

  always_comb begin
    sum_ext  = {1'b0, acc_in} + {1'b0, alu_x};
    // The extra top bit of the difference is the unsigned borrow (A < X).
    diff_ext = {1'b0, acc_in} - {1'b0, alu_x};
    op_res   = acc_in;
    op_c     = 1'b0;
    op_v     = 1'b0;
    case (op)
      OP_ADD: begin
        op_res = sum_ext[WIDTH-1:0];
        op_c   = sum_ext[WIDTH];
        op_v   = (acc_in[WIDTH-1] == alu_x[WIDTH-1]) &&
                 (sum_ext[WIDTH-1] != acc_in[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff_ext[WIDTH-1:0];
        op_c   = diff_ext[WIDTH];
        op_v   = (acc_in[WIDTH-1] != alu_x[WIDTH-1]) &&
                 (diff_ext[WIDTH-1] != acc_in[WIDTH-1]);
      end
      OP_AND: op_res = acc_in & alu_x;
      OP_OR:  op_res = acc_in | alu_x;
      OP_NOT: op_res = ~alu_x;
      OP_SHL: begin
        op_res = {acc_in[WIDTH-2:0], 1'b0};
        op_c   = acc_in[WIDTH-1];
      end
      OP_SHR: begin
        op_res = {1'b0, acc_in[WIDTH-1:1]};
        op_c   = acc_in[0];
      end
      default: op_res = acc_in;
    endcase
  end

  // ---------------- multiplier step ----------------
  // Right-shifting shift-add: the partial sum enters at the top of the
  // product and shifts down; after WIDTH steps the full product is formed.
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;

  always_comb begin
    step_sum = mplier[0] ? ({1'b0, prod_hi} + {1'b0, mcand}) : {1'b0, prod_hi};
    next_hi  = step_sum[WIDTH:1];
    next_lo  = {step_sum[0], prod_lo[WIDTH-1:1]};
  end

  // ---------------- control and registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      mplier    <= '0;
      prod_hi   <= '0;
      prod_lo   <= '0;
      count     <= '0;
      result    <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand   <= acc_in;
              mplier  <= alu_x;
              prod_hi <= '0;
              prod_lo <= '0;
              count   <= '0;
              busy    <= 1'b1;
              state   <= S_MUL;
            end else begin
              result    <= op_res;
              result_hi <= '0;
              flag_z    <= (op_res == '0);
              flag_n    <= op_res[WIDTH-1];
              flag_c    <= op_c;
              flag_v    <= op_v;
              done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          prod_hi <= next_hi;
          prod_lo <= next_lo;
          mplier  <= {1'b0, mplier[WIDTH-1:1]};
          count   <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            result    <= next_lo;
            result_hi <= next_hi;
            flag_z    <= ({next_hi, next_lo} == '0);
            flag_n    <= next_hi[WIDTH-1];
            flag_c    <= 1'b0;
            flag_v    <= (next_hi != '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [15:0] acc_in;
  logic [15:0] alu_x;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        flag_z, flag_n, flag_c, flag_v;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .acc_in(acc_in), .alu_x(alu_x),
    .result(result), .result_hi(result_hi),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .busy(busy), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] x;
    logic [15:0] res;
    logic        z, n, c, v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [15:0] hi, input logic [15:0] lo,
                            input logic z, input logic n, input logic c, input logic v);
    check({name, "_result"},    {16'h0, result},    {16'h0, lo});
    check({name, "_result_hi"}, {16'h0, result_hi}, {16'h0, hi});
    check({name, "_flags"}, {28'h0, flag_z, flag_n, flag_c, flag_v}, {28'h0, z, n, c, v});
  endtask

  task automatic do_mul(input string name, input logic [15:0] a, input logic [15:0] x,
                        input logic interfere, input logic [15:0] eh, input logic [15:0] el,
                        input logic ez, input logic en, input logic ev);
    int cyc;
    logic busy_ok;
    cyc = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = 4'd7; acc_in = a; alu_x = x;
    @(posedge clk); #1;
    check({name, "_busy_set"}, busy, 1);
    check({name, "_no_early_done"}, done, 0);
    @(negedge clk);
    start = 1'b0; acc_in = 16'h5555; alu_x = 16'hAAAA;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin cyc = i; break; end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      // Hold start/ADD high across the edge of step 5 and change X.
      start = interfere && (i == 4);
      op    = (interfere && (i == 4)) ? 4'd0 : 4'd7;
      if (interfere && i == 4) alu_x = 16'hFFFF;
    end
    check({name, "_latency"}, cyc, 16);
    check({name, "_busy_held"}, busy_ok, 1);
    check({name, "_busy_clear"}, busy, 0);
    check_outs(name, eh, el, ez, en, 1'b0, ev);
    @(posedge clk); #1;
    check({name, "_done_single"}, done, 0);
    check({name, "_result_held"}, result, el);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = 4'd0; acc_in = 16'h1111; alu_x = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_outs("reset", 16'h0, 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    //          name        op     A        X        result   z  n  c  v
    vecs.push_back('{"add_ovf",  4'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1});
    vecs.push_back('{"sub_brw",  4'd1, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0});
    vecs.push_back('{"sub_zero", 4'd1, 16'h1234, 16'h1234, 16'h0000, 1, 0, 0, 0});
    vecs.push_back('{"shl",      4'd5, 16'h8001, 16'h0000, 16'h0002, 0, 0, 1, 0});
    vecs.push_back('{"shr",      4'd6, 16'h8001, 16'h0000, 16'h4000, 0, 0, 1, 0});
    vecs.push_back('{"not",      4'd4, 16'h0000, 16'h00FF, 16'hFF00, 0, 1, 0, 0});
    vecs.push_back('{"and",      4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0});
    vecs.push_back('{"or",       4'd3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 1, 0, 0});
    vecs.push_back('{"add_wrap", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0});
    vecs.push_back('{"sub_ovf",  4'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1});
    vecs.push_back('{"pass9",    4'd9, 16'hABCD, 16'h1234, 16'hABCD, 0, 1, 0, 0});
    vecs.push_back('{"pass15",   4'd15,16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0, 0});

    // Back-to-back: start stays high, a new op completes every cycle.
    foreach (vecs[i]) begin
      @(negedge clk);
      start = 1'b1; op = vecs[i].op; acc_in = vecs[i].a; alu_x = vecs[i].x;
      @(posedge clk); #1;
      check({vecs[i].name, "_done"}, done, 1);
      check({vecs[i].name, "_busy"}, busy, 0);
      check_outs(vecs[i].name, 16'h0, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v);
    end
    @(negedge clk);
    start = 1'b0; acc_in = 16'h0001; alu_x = 16'h0001;
    @(posedge clk); #1;
    check("idle_done_low", done, 0);
    check_outs("idle_hold", 16'h0, 16'h0000, 1, 0, 0, 0);

    do_mul("mul_a", 16'h1234, 16'h0100, 1'b0, 16'h0012, 16'h3400, 0, 0, 1);
    do_mul("mul_max", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 0, 1, 1);
    do_mul("mul_intf", 16'h1234, 16'h0100, 1'b1, 16'h0012, 16'h3400, 0, 0, 1);
    do_mul("mul_zero", 16'h0000, 16'hBEEF, 1'b0, 16'h0000, 16'h0000, 1, 0, 0);
    do_mul("mul_small", 16'h0003, 16'h0007, 1'b0, 16'h0000, 16'h0015, 0, 0, 0);

    // Reset in the middle of a multiply, after step 8.
    do_mul("mul_pre", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 0, 1, 1);
    @(negedge clk);
    start = 1'b1; op = 4'd7; acc_in = 16'h1234; alu_x = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy_before_rst", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check_outs("rst_mid", 16'h0, 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      check("rst_no_stray_done", done, 0);
    end
    @(negedge clk);
    start = 1'b1; op = 4'd0; acc_in = 16'h0002; alu_x = 16'h0003;
    @(posedge clk); #1;
    check("post_rst_add_done", done, 1);
    check_outs("post_rst_add", 16'h0, 16'h0005, 0, 0, 0, 0);
    @(negedge clk);
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
